// File: rtl/div_unit.sv
// 32-cycle restoring divider (DIV/DIVU) producing quotient on lo and remainder on hi.
// Define DIV_UNSIGNED_EN to add the unsigned_op input for unsigned division.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
   input  logic              unsigned_op,
`endif
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PREP = 3'd1;
   localparam logic [2:0] RUN  = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

   logic [2:0]               state;
   logic [5:0]               count;
   logic                     neg_q;
   logic                     neg_r;
   logic [DATA_W-1:0]        dvd_abs;
   logic [DATA_W-1:0]        dvs_abs;
   logic [DATA_W-1:0]        rem;
   logic [DATA_W-1:0]        quo;
   logic [DATA_W:0]          shifted;
   logic [DATA_W:0]          diff;
   logic                     fits;
   logic                     uns_req;
   logic signed [DATA_W-1:0] dvd_s;
   logic signed [DATA_W-1:0] dvs_s;

   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                    input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
      return apply_sign(v, v[DATA_W-1]);
   endfunction

`ifdef DIV_UNSIGNED_EN
   assign uns_req = unsigned_op;
`else
   assign uns_req = 1'b0;
`endif

   assign dvd_s = dividend;
   assign dvs_s = divisor;

   // One restoring step: a set carry-out of the shift means the partial
   // remainder already exceeds any 32-bit divisor, so the subtract always fits.
   always_comb begin
      shifted = {rem, quo[DATA_W-1]};
      diff    = shifted - {1'b0, dvs_abs};
      fits    = shifted[DATA_W] | ~diff[DATA_W];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dvd_abs  <= '0;
         dvs_abs  <= '0;
         rem      <= '0;
         quo      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  neg_q   <= ~uns_req & (dvd_s[DATA_W-1] ^ dvs_s[DATA_W-1]);
                  neg_r   <= ~uns_req & dvd_s[DATA_W-1];
                  dvd_abs <= uns_req ? dividend : magnitude(dvd_s);
                  dvs_abs <= uns_req ? divisor  : magnitude(dvs_s);
                  busy    <= 1'b1;
                  if (divisor == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state <= PREP;
                  end
               end
            end
            PREP: begin
               rem   <= '0;
               quo   <= dvd_abs;
               count <= '0;
               state <= RUN;
            end
            RUN: begin
               if (fits) begin
                  rem <= diff[DATA_W-1:0];
                  quo <= {quo[DATA_W-2:0], 1'b1};
               end else begin
                  rem <= shifted[DATA_W-1:0];
                  quo <= {quo[DATA_W-2:0], 1'b0};
               end
               count <= count + 6'd1;
               if (count == LAST_STEP) state <= FIX;
            end
            FIX: begin
               lo    <= apply_sign(quo, neg_q);
               hi    <= apply_sign(rem, neg_r);
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
